// File: rtl/tim_dma.sv
// Single-outstanding memory initiator that copies or fills a block of words over the TIM handshake.
// Optional TIM_DMA_TIMEOUT_EN aborts a stalled response after TIMEOUT cycles and raises error.
module tim_dma #(
    parameter int LEN_WIDTH = 16,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 mode,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_WIDTH-1:0] length,
    input  logic [31:0]          fill_data,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [LEN_WIDTH-1:0] count,
    output logic                 mem_valid,
    output logic                 mem_instr,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_wstrb,
    input  logic [31:0]          mem_rdata,
    input  logic                 mem_ready
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [31:0]          src_q, src_d;
    logic [31:0]          dst_q, dst_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] count_q, count_d;
    logic [31:0]          buf_q, buf_d;
    logic                 mode_q, mode_d;
    logic                 error_q, error_d;
    logic                 unused_ok;

`ifdef TIM_DMA_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    assign unused_ok = ^{src_addr[1:0], dst_addr[1:0]};
`else
    assign unused_ok = ^{src_addr[1:0], dst_addr[1:0], (TIMEOUT != 0)};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            count_q <= '0;
            buf_q   <= '0;
            mode_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef TIM_DMA_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            len_q   <= len_d;
            count_q <= count_d;
            buf_q   <= buf_d;
            mode_q  <= mode_d;
            error_q <= error_d;
`ifdef TIM_DMA_TIMEOUT_EN
            tmo_q   <= tmo_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        len_d     = len_q;
        count_d   = count_q;
        buf_d     = buf_q;
        mode_d    = mode_q;
        error_d   = error_q;
        mem_valid = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = 4'h0;
`ifdef TIM_DMA_TIMEOUT_EN
        tmo_d     = tmo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d   = {src_addr[31:2], 2'b00};
                    dst_d   = {dst_addr[31:2], 2'b00};
                    len_d   = length;
                    mode_d  = mode;
                    // Fill mode reuses the data buffer as the constant write word.
                    buf_d   = mode ? fill_data : '0;
                    count_d = '0;
                    error_d = 1'b0;
                    if (length == '0)
                        state_d = S_DONE;
                    else
                        state_d = mode ? S_WR_REQ : S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                mem_valid = 1'b1;
                mem_addr  = src_q;
                state_d   = S_RD_WAIT;
`ifdef TIM_DMA_TIMEOUT_EN
                tmo_d     = '0;
`endif
            end
            S_RD_WAIT: begin
                if (mem_ready) begin
                    buf_d   = mem_rdata;
                    state_d = S_WR_REQ;
                end
`ifdef TIM_DMA_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            S_WR_REQ: begin
                mem_valid = 1'b1;
                mem_addr  = dst_q;
                mem_wdata = buf_q;
                mem_wstrb = 4'hF;
                state_d   = S_WR_WAIT;
`ifdef TIM_DMA_TIMEOUT_EN
                tmo_d     = '0;
`endif
            end
            S_WR_WAIT: begin
                if (mem_ready) begin
                    count_d = count_q + 1'b1;
                    src_d   = src_q + 32'd4;
                    dst_d   = dst_q + 32'd4;
                    if (count_q + 1'b1 == len_q)
                        state_d = S_DONE;
                    else
                        state_d = mode_q ? S_WR_REQ : S_RD_REQ;
                end
`ifdef TIM_DMA_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    error_d = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign error     = error_q;
    assign count     = count_q;
    assign mem_instr = 1'b0;

endmodule

// File: tb/tb_tim_dma.sv
// Directed bench for tim_dma: a 1-cycle memory responder checks every write against a scoreboard.
module tb_tim_dma;
    localparam int LW = 16;

    logic          clock = 1'b0;
    logic          reset, start, mode;
    logic [31:0]   src_addr, dst_addr, fill_data;
    logic [LW-1:0] length;
    logic          busy, done, error;
    logic [LW-1:0] count;
    logic          mem_valid, mem_instr;
    logic [31:0]   mem_addr, mem_wdata;
    logic [3:0]    mem_wstrb;
    logic [31:0]   mem_rdata = '0;
    logic          mem_ready = 1'b0;

    always #5 clock = ~clock;

    tim_dma #(.LEN_WIDTH(LW), .TIMEOUT(8)) dut (
        .clock(clock), .reset(reset), .start(start), .mode(mode),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length), .fill_data(fill_data),
        .busy(busy), .done(done), .error(error), .count(count),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int tests = 0, fails = 0;
    int n_reads = 0, n_writes = 0;
    bit resp_en = 1'b1;
    int lat;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory responder: answers every request one cycle later and scores writes.
    always @(posedge clock) begin
        mem_ready <= 1'b0;
        if (mem_valid) begin
            check("instr", {31'd0, mem_instr}, 32'd0);
            if (mem_wstrb == 4'hF) begin
                n_writes++;
                mem[mem_addr] = mem_wdata;
                if (exp_addr_q.size() == 0) begin
                    check("sb_unexpected_write", mem_addr, 32'hFFFF_FFFF);
                end else begin
                    check("sb_waddr", mem_addr, exp_addr_q.pop_front());
                    check("sb_wdata", mem_wdata, exp_data_q.pop_front());
                end
            end else begin
                n_reads++;
                check("rd_wstrb", {28'd0, mem_wstrb}, 32'd0);
                mem_rdata <= mem.exists(mem_addr) ? mem[mem_addr] : 32'hBAD0_BAD0;
            end
            if (resp_en) mem_ready <= 1'b1;
        end
    end

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
        exp_addr_q.push_back(a);
        exp_data_q.push_back(d);
    endtask

    // Launch a transfer (start sampled at the next edge = cycle 0) and measure cycles to done.
    task automatic run(input bit m, input logic [31:0] s, input logic [31:0] d,
                       input logic [31:0] f, input logic [LW-1:0] len, input bit hold,
                       output int l);
        n_reads = 0;
        n_writes = 0;
        mode = m; src_addr = s; dst_addr = d; fill_data = f; length = len;
        start = 1'b1;
        @(posedge clock); #1;
        l = 1;
        if (!hold) start = 1'b0;
        mode = ~m; src_addr = 32'h0BAD_0000; dst_addr = 32'h0BAD_1000;
        fill_data = 32'h0; length = 16'd7;
        while (!done && l < 300) begin
            @(posedge clock); #1;
            if (l == 1) start = 1'b0;
            l++;
        end
        start = 1'b0;
        check("done_seen", {31'd0, done}, 32'd1);
        @(posedge clock); #1;
        check("done_pulse_width", {31'd0, done}, 32'd0);
        check("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        bit saw_done;
        reset = 1'b1; start = 1'b0; mode = 1'b0;
        src_addr = '0; dst_addr = '0; fill_data = '0; length = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_count", {16'd0, count}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        reset = 1'b0;

        mem[32'h100] = 32'h1111_1111;
        mem[32'h104] = 32'h2222_2222;
        mem[32'h108] = 32'h3333_3333;
        mem[32'h10C] = 32'h4444_4444;
        mem[32'h110] = 32'h5555_5555;

        // Copy three words
        push_exp(32'h200, 32'h1111_1111);
        push_exp(32'h204, 32'h2222_2222);
        push_exp(32'h208, 32'h3333_3333);
        run(1'b0, 32'h100, 32'h200, 32'h0, 16'd3, 1'b0, lat);
        check("copy_latency", lat, 32'd13);
        check("copy_count", {16'd0, count}, 32'd3);
        check("copy_error", {31'd0, error}, 32'd0);
        check("copy_reads", n_reads, 32'd3);
        check("copy_writes", n_writes, 32'd3);
        check("copy_sb_empty", exp_addr_q.size(), 32'd0);
        check("copy_dst_word2", mem[32'h208], 32'h3333_3333);

        // Fill four words, start held high an extra cycle while busy
        for (int i = 0; i < 4; i++) push_exp(32'h40 + 32'(4 * i), 32'hDEAD_BEEF);
        run(1'b1, 32'h0, 32'h40, 32'hDEAD_BEEF, 16'd4, 1'b1, lat);
        check("fill_latency", lat, 32'd9);
        check("fill_count", {16'd0, count}, 32'd4);
        check("fill_reads", n_reads, 32'd0);
        check("fill_writes", n_writes, 32'd4);
        check("fill_sb_empty", exp_addr_q.size(), 32'd0);

        // Zero length
        run(1'b0, 32'h100, 32'h200, 32'h0, 16'd0, 1'b0, lat);
        check("len0_latency", lat, 32'd1);
        check("len0_requests", n_reads + n_writes, 32'd0);
        check("len0_count", {16'd0, count}, 32'd0);

        // Destination pointer wraps; low address bits are ignored
        push_exp(32'hFFFF_FFFC, 32'hA5A5_A5A5);
        push_exp(32'h0000_0000, 32'hA5A5_A5A5);
        run(1'b1, 32'h0, 32'hFFFF_FFFE, 32'hA5A5_A5A5, 16'd2, 1'b0, lat);
        check("wrap_latency", lat, 32'd5);
        check("wrap_writes", n_writes, 32'd2);
        check("wrap_sb_empty", exp_addr_q.size(), 32'd0);

        // Reset while a copy read is in flight
        n_reads = 0; n_writes = 0;
        mode = 1'b0; src_addr = 32'h100; dst_addr = 32'h600; length = 16'd5;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        check("mid_rdreq_valid", {31'd0, mem_valid}, 32'd1);
        check("mid_rdreq_addr", mem_addr, 32'h100);
        @(posedge clock); #1;
        check("mid_rdwait_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_valid", {31'd0, mem_valid}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        saw_done = 1'b0;
        repeat (6) begin
            @(posedge clock); #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("mid_rst_quiet", {31'd0, saw_done}, 32'd0);
        check("mid_rst_writes", n_writes, 32'd0);

        push_exp(32'h300, 32'h1234_5678);
        run(1'b1, 32'h0, 32'h300, 32'h1234_5678, 16'd1, 1'b0, lat);
        check("restart_latency", lat, 32'd3);
        check("restart_count", {16'd0, count}, 32'd1);
        check("restart_sb_empty", exp_addr_q.size(), 32'd0);

`ifdef TIM_DMA_TIMEOUT_EN
        // Responder stalls: the transfer must abort with error and zero words done
        resp_en = 1'b0;
        push_exp(32'h500, 32'h7777_7777);
        run(1'b1, 32'h0, 32'h500, 32'h7777_7777, 16'd2, 1'b0, lat);
        check("tmo_error", {31'd0, error}, 32'd1);
        check("tmo_count", {16'd0, count}, 32'd0);
        check("tmo_latency", lat, 32'd10);
        resp_en = 1'b1;
        run(1'b0, 32'h0, 32'h0, 32'h0, 16'd0, 1'b0, lat);
        check("tmo_error_cleared", {31'd0, error}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
